// File: rtl/min_frame_arbiter_if.sv
// Handshake bundle for min_frame_arbiter: two sample requesters in, one frame result out.
// Signal names match the arbiter's documented port list.
interface min_frame_arbiter_if #(
  parameter int DW = 2
);
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_last;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_last;
  logic          req1_ready;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_min;
  logic          res_id;
  logic [7:0]    res_len;
  logic          res_trunc;

  // Requesters and the result consumer sit on the master side.
  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_min, res_id, res_len, res_trunc
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_min, res_id, res_len, res_trunc
  );
endinterface

// File: rtl/min_frame_arbiter.sv
// Two-requester frame arbiter: grants one requester a whole frame, tracks the minimum
// sample and length, then holds the result until the consumer takes it.
module min_frame_arbiter #(
  parameter int DW      = 2,
  parameter int MAX_LEN = 8
) (
  input logic                clk,
  input logic                rst,
  min_frame_arbiter_if.slave bus
);

  localparam logic [7:0] MaxLenC = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          rrPtr_q, rrPtr_d;
  logic [DW-1:0] minVal_q, minVal_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          trunc_q, trunc_d;

  logic          selValid;
  logic [DW-1:0] selData;
  logic          selLast;
  logic [7:0]    nextCnt;
  logic [DW-1:0] nextMin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      rrPtr_q  <= 1'b0;
      minVal_q <= '1;
      cnt_q    <= 8'd0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rrPtr_q  <= rrPtr_d;
      minVal_q <= minVal_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rrPtr_d  = rrPtr_q;
    minVal_d = minVal_q;
    cnt_d    = cnt_q;
    trunc_d  = trunc_q;
    selValid = grant_q ? bus.req1_valid : bus.req0_valid;
    selData  = grant_q ? bus.req1_data  : bus.req0_data;
    selLast  = grant_q ? bus.req1_last  : bus.req0_last;
    nextCnt  = cnt_q + 8'd1;
    nextMin  = (selData < minVal_q) ? selData : minVal_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          grant_d  = (bus.req0_valid && bus.req1_valid) ? rrPtr_q : bus.req1_valid;
          minVal_d = '1;
          cnt_d    = 8'd0;
          trunc_d  = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // A last-flagged sample wins over the length limit, so such frames never report truncation.
        if (selValid) begin
          minVal_d = nextMin;
          cnt_d    = nextCnt;
          if (selLast) begin
            trunc_d = 1'b0;
            state_d = DONE;
          end else if (nextCnt == MaxLenC) begin
            trunc_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          rrPtr_d = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by reset so they read zero while reset is held, not just after the edge.
  assign bus.req0_ready = !rst && (state_q == RUN) && !grant_q;
  assign bus.req1_ready = !rst && (state_q == RUN) &&  grant_q;
  assign bus.res_valid  = !rst && (state_q == DONE);
  assign bus.res_min    = bus.res_valid ? minVal_q : '0;
  assign bus.res_id     = bus.res_valid ? grant_q  : 1'b0;
  assign bus.res_len    = bus.res_valid ? cnt_q    : 8'd0;
  assign bus.res_trunc  = bus.res_valid ? trunc_q  : 1'b0;

endmodule
